kronos_lsu_stb: RTL
===================

// Module: kronos_lsu_stb
// PURPOSE
// Load/store unit with a posted store buffer. Sits in the WB stage and drives the
// word-aligned data memory port (data_req/data_ack). Stores retire one cycle after
// start; buffered stores drain to memory in the background. Loads and fences are
// ordered behind all buffered stores. Misaligned accesses are either split into two
// aligned accesses or rejected, selected by parameter.
// PARAMETERS
// STB_DEPTH      4  store buffer entries, power of 2, >=2 (a split store uses 2 entries)
// MISALIGN_SPLIT 1  1: split boundary-crossing access into 2 words; 0: reject it
// PORTS
// clk              in   1   clock
// rstz             in   1   asynchronous active-low reset
// addr             in   32  byte address of access
// store_data       in   32  store data, LSB-justified
// start            in   1   request; held high by WB until done
// ld / st / fence  in   1   op select, one-hot, valid with start
// rd               in   5   load destination register
// data_size        in   2   BYTE/HALF/WORD (kronos_types)
// data_uns         in   1   zero-extend load
// done             out  1   1-cycle pulse: op complete
// addr_misaligned  out  1   comb: addr % size != 0
// load_data        out  32  aligned, extended load result; valid while done
// load_rd          out  5   load destination
// load_write       out  1   done & ld & rd!=0 & access performed
// stb_empty        out  1   store buffer holds no entries
// data_addr        out  32  word address, [1:0]=0
// data_rd_data     in   32  read data
// data_wr_data     out  32  write data, byte lanes pre-rotated
// data_wr_mask     out  4   byte enables; 4'hF on reads
// data_wr_en       out  1   write request qualifier
// data_req         out  1   bus request; held until data_ack
// data_ack         in   1   bus acknowledge, 1 cycle
// BEHAVIOUR
// - Reset: state IDLE, buffer empty, data_req=0, data_wr_en=0, done=0, load_write=0,
//   stb_empty=1. Reset mid-op discards buffered stores and in-flight requests.
// - Boundary cross: HALF at byte 3, or WORD at byte !=0. Entry 0 holds {word addr,
//   rotated data, wmask[3:0]}; entry 1 holds {addr+4, same data, wmask[7:4]}.
// - Store: accepted in IDLE when free slots >= entries needed (1 or 2); enqueue that
//   cycle, done next cycle. Otherwise wait in IDLE, start held.
// - MISALIGN_SPLIT=0 and cross: no bus access, no enqueue; done next cycle,
//   load_write=0. Trap is raised upstream from addr_misaligned.
// - Drain: while buffer non-empty and the bus port is not used by a load, present the
//   head with data_req=data_wr_en=1. Pop on data_ack. Next head issues the cycle after.
// - Load: wait until stb_empty, then READ1 -> (cross) READ2 -> LOAD -> IDLE.
//   READ uses data_wr_mask=4'hF. Rotate right by offset; merge the two words as in the
//   split case; sign/zero-extend. done and load_write in LOAD only.
// - Fence: done the cycle after stb_empty is seen with start&fence; no bus access.
// - Enqueue and pop in the same cycle are both legal; the count is unchanged.
//   Full is computed against slots needed.
// - data_req never drops without data_ack. data_addr, data_wr_* are stable while
//   data_req=1.
// - Pointers are $clog2(STB_DEPTH) bits and wrap. count has one extra bit.
// - States: IDLE, READ1, READ2, LOAD, ACK (store/fence/reject done).
// STRUCTURE
// - kronos_types: add typedef stb_entry_t {logic [31:0] addr, data; logic [3:0] mask;}.
//   Reuse BYTE/HALF/WORD.
// - Sub-module kronos_lsu_stb_fifo: STB_DEPTH x stb_entry_t circular buffer.
//   Ports: push, push2, pop, head, count, empty, free.
// TESTING
// - SB 0xAB @0x103 -> done at T+1; one write: addr 0x100, mask 4'b1000,
//   data[31:24]=0xAB.
// - SW 0x11223344 @0x202 -> 2 entries: {0x200, 4'b1100} then {0x204, 4'b0011};
//   loading LW @0x202 afterwards returns 0x11223344.
// - STB_DEPTH=2: SW, SW, SW with data_ack withheld -> third done waits until the first
//   entry pops.
// - LH @0x003 mem[0]=0x80000000, mem[4]=0x000000FF, data_uns=0 -> 0xFFFFFF80
//   (halfword 0xFF80 sign-extended); data_uns=1 -> 0x0000FF80.
// - Fence with 3 buffered stores -> done exactly one cycle after the 3rd data_ack.
// - MISALIGN_SPLIT=0, LW @0x001 -> done, load_write=0, no data_req; rstz low
//   mid-drain -> data_req=0, stb_empty=1.

Source files
------------

// File: rtl/kronos_lsu_stb_pkg.sv
// Shared encodings, the store-buffer entry type and byte-lane helpers
// for the load/store unit with a posted store buffer.
package kronos_lsu_stb_pkg;

  localparam logic [1:0] BYTE = 2'b00;
  localparam logic [1:0] HALF = 2'b01;
  localparam logic [1:0] WORD = 2'b10;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } stb_entry_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ1 = 3'd1,
    READ2 = 3'd2,
    LOAD  = 3'd3,
    ACK   = 3'd4
  } lsu_state_e;

  function automatic logic crosses_word(input logic [1:0] size, input logic [1:0] off);
    logic r;
    case (size)
      HALF:    r = (off == 2'd3);
      WORD:    r = (off != 2'd0);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic r;
    case (size)
      HALF:    r = off[0];
      WORD:    r = (off != 2'd0);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // 8-bit mask spanning two words: [3:0] first word, [7:4] following word
  function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [7:0] m;
    case (size)
      BYTE:    m = 8'h01;
      HALF:    m = 8'h03;
      default: m = 8'h0F;
    endcase
    return m << off;
  endfunction

  function automatic logic [31:0] rotl_bytes(input logic [31:0] d, input logic [1:0] off);
    logic [31:0] r;
    case (off)
      2'd0:    r = d;
      2'd1:    r = {d[23:0], d[31:24]};
      2'd2:    r = {d[15:0], d[31:16]};
      default: r = {d[7:0], d[31:8]};
    endcase
    return r;
  endfunction

  // Shift the {hi,lo} word pair right by the byte offset, then extend
  function automatic logic [31:0] load_extract(input logic [31:0] lo, input logic [31:0] hi,
                                               input logic [1:0] off, input logic [1:0] size,
                                               input logic uns);
    logic [31:0] raw;
    logic [31:0] r;
    case (off)
      2'd0:    raw = lo;
      2'd1:    raw = {hi[7:0], lo[31:8]};
      2'd2:    raw = {hi[15:0], lo[31:16]};
      default: raw = {hi[23:0], lo[31:24]};
    endcase
    case (size)
      BYTE:    r = {{24{raw[7] & ~uns}}, raw[7:0]};
      HALF:    r = {{16{raw[15] & ~uns}}, raw[15:0]};
      default: r = raw;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/kronos_lsu_stb_fifo.sv
// Circular store buffer; a split store pushes two consecutive entries in one cycle.
module kronos_lsu_stb_fifo
  import kronos_lsu_stb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rstz,
  input  logic                       push,
  input  logic                       push2,
  input  stb_entry_t                 entry0,
  input  stb_entry_t                 entry1,
  input  logic                       pop,
  output stb_entry_t                 head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     free
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  stb_entry_t      mem_r [DEPTH];
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic [CW-1:0]   inc_s;
  logic [CW-1:0]   dec_s;

  // Number of entries added and removed this cycle
  always_comb begin
    inc_s = {CW{1'b0}};
    dec_s = {CW{1'b0}};
    if (push) begin
      if (push2) begin
        inc_s = CW'(2'd2);
      end else begin
        inc_s = CW'(1'b1);
      end
    end else begin
      inc_s = {CW{1'b0}};
    end
    if (pop) begin
      dec_s = CW'(1'b1);
    end else begin
      dec_s = {CW{1'b0}};
    end
  end

  // Storage, pointers and occupancy
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= entry0;
        if (push2) begin
          mem_r[wr_ptr_r + PW'(1'b1)] <= entry1;
          wr_ptr_r <= wr_ptr_r + PW'(2'd2);
        end else begin
          wr_ptr_r <= wr_ptr_r + PW'(1'b1);
        end
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + PW'(1'b1);
      end
      count_r <= count_r + inc_s - dec_s;
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;
  assign empty = (count_r == {CW{1'b0}});
  assign free  = CW'(DEPTH) - count_r;

endmodule

// File: rtl/kronos_lsu_stb.sv
// WB-stage load/store unit: posted stores drain in the background; loads and
// fences wait for the buffer to empty; boundary-crossing accesses split or reject.
module kronos_lsu_stb
  import kronos_lsu_stb_pkg::*;
#(
  parameter int STB_DEPTH      = 4,
  parameter int MISALIGN_SPLIT = 1
) (
  input  logic        clk,
  input  logic        rstz,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic        start,
  input  logic        ld,
  input  logic        st,
  input  logic        fence,
  input  logic [4:0]  rd,
  input  logic [1:0]  data_size,
  input  logic        data_uns,
  output logic        done,
  output logic        addr_misaligned,
  output logic [31:0] load_data,
  output logic [4:0]  load_rd,
  output logic        load_write,
  output logic        stb_empty,
  output logic [31:0] data_addr,
  input  logic [31:0] data_rd_data,
  output logic [31:0] data_wr_data,
  output logic [3:0]  data_wr_mask,
  output logic        data_wr_en,
  output logic        data_req,
  input  logic        data_ack
);

  localparam int CW = $clog2(STB_DEPTH) + 1;

  lsu_state_e    state_r;
  logic          done_r;
  logic          load_write_r;
  logic [31:0]   load_data_r;
  logic [4:0]    load_rd_r;
  logic [31:0]   lo_word_r;
  logic          data_req_r;
  logic          data_wr_en_r;
  logic [31:0]   data_addr_r;
  logic [31:0]   data_wr_data_r;
  logic [3:0]    data_wr_mask_r;

  logic [1:0]    off_s;
  logic          cross_s;
  logic          reject_s;
  logic [7:0]    wmask_s;
  logic [31:0]   wdata_s;
  logic [31:0]   addr_word_s;
  logic [31:0]   addr_next_s;
  logic [CW-1:0] need_s;
  logic [CW-1:0] count_s;
  logic [CW-1:0] free_s;
  logic          push_s;
  logic          push2_s;
  logic          pop_s;
  logic          empty_s;
  logic          empty_next_s;
  stb_entry_t    entry0_s;
  stb_entry_t    entry1_s;
  stb_entry_t    head_s;

  assign off_s       = addr[1:0];
  assign cross_s     = crosses_word(data_size, off_s);
  assign reject_s    = cross_s && (MISALIGN_SPLIT == 0);
  assign wmask_s     = lane_mask(data_size, off_s);
  assign wdata_s     = rotl_bytes(store_data, off_s);
  assign addr_word_s = {addr[31:2], 2'b00};
  assign addr_next_s = addr_word_s + 32'd4;

  assign entry0_s = '{addr: addr_word_s, data: wdata_s, mask: wmask_s[3:0]};
  assign entry1_s = '{addr: addr_next_s, data: wdata_s, mask: wmask_s[7:4]};

  // Store acceptance and drain handshake
  always_comb begin
    need_s  = CW'(1'b1);
    push_s  = 1'b0;
    push2_s = 1'b0;
    if (cross_s) begin
      need_s = CW'(2'd2);
    end else begin
      need_s = CW'(1'b1);
    end
    if ((state_r == IDLE) && start && st && !reject_s && (free_s >= need_s)) begin
      push_s  = 1'b1;
      push2_s = cross_s;
    end else begin
      push_s  = 1'b0;
      push2_s = 1'b0;
    end
  end

  assign pop_s = data_req_r && data_wr_en_r && data_ack;
  // Last entry leaving this cycle lets a load or fence proceed without a bubble
  assign empty_next_s = empty_s || ((count_s == CW'(1'b1)) && pop_s);

  kronos_lsu_stb_fifo #(
    .DEPTH (STB_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rstz   (rstz),
    .push   (push_s),
    .push2  (push2_s),
    .entry0 (entry0_s),
    .entry1 (entry1_s),
    .pop    (pop_s),
    .head   (head_s),
    .count  (count_s),
    .empty  (empty_s),
    .free   (free_s)
  );

  // Operation FSM plus shared memory port (load reads and buffer drain)
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state_r        <= IDLE;
      done_r         <= 1'b0;
      load_write_r   <= 1'b0;
      load_data_r    <= 32'h0000_0000;
      load_rd_r      <= 5'd0;
      lo_word_r      <= 32'h0000_0000;
      data_req_r     <= 1'b0;
      data_wr_en_r   <= 1'b0;
      data_addr_r    <= 32'h0000_0000;
      data_wr_data_r <= 32'h0000_0000;
      data_wr_mask_r <= 4'h0;
    end else begin
      done_r       <= 1'b0;
      load_write_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start && st && (reject_s || push_s)) begin
            state_r <= ACK;
            done_r  <= 1'b1;
          end else if (start && ld && reject_s) begin
            state_r <= ACK;
            done_r  <= 1'b1;
          end else if (start && ld && empty_next_s) begin
            state_r <= READ1;
          end else if (start && fence && empty_next_s) begin
            state_r <= ACK;
            done_r  <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        READ1: begin
          if (!data_req_r) begin
            data_req_r     <= 1'b1;
            data_wr_en_r   <= 1'b0;
            data_addr_r    <= addr_word_s;
            data_wr_mask_r <= 4'hF;
          end else if (data_ack) begin
            data_req_r <= 1'b0;
            lo_word_r  <= data_rd_data;
            if (cross_s) begin
              state_r <= READ2;
            end else begin
              state_r      <= LOAD;
              done_r       <= 1'b1;
              load_write_r <= (rd != 5'd0);
              load_rd_r    <= rd;
              load_data_r  <= load_extract(data_rd_data, data_rd_data, off_s, data_size, data_uns);
            end
          end else begin
            state_r <= READ1;
          end
        end
        READ2: begin
          if (!data_req_r) begin
            data_req_r     <= 1'b1;
            data_wr_en_r   <= 1'b0;
            data_addr_r    <= addr_next_s;
            data_wr_mask_r <= 4'hF;
          end else if (data_ack) begin
            data_req_r   <= 1'b0;
            state_r      <= LOAD;
            done_r       <= 1'b1;
            load_write_r <= (rd != 5'd0);
            load_rd_r    <= rd;
            load_data_r  <= load_extract(lo_word_r, data_rd_data, off_s, data_size, data_uns);
          end else begin
            state_r <= READ2;
          end
        end
        LOAD:    state_r <= IDLE;
        ACK:     state_r <= IDLE;
        default: state_r <= IDLE;
      endcase

      // Background drain owns the port whenever no load is reading
      if ((state_r != READ1) && (state_r != READ2)) begin
        if (data_req_r) begin
          if (data_ack) begin
            data_req_r <= 1'b0;
          end else begin
            data_req_r <= 1'b1;
          end
        end else if (!empty_s) begin
          data_req_r     <= 1'b1;
          data_wr_en_r   <= 1'b1;
          data_addr_r    <= head_s.addr;
          data_wr_data_r <= head_s.data;
          data_wr_mask_r <= head_s.mask;
        end else begin
          data_req_r <= 1'b0;
        end
      end
    end
  end

  assign done            = done_r;
  assign addr_misaligned = is_misaligned(data_size, off_s);
  assign load_data       = load_data_r;
  assign load_rd         = load_rd_r;
  assign load_write      = load_write_r;
  assign stb_empty       = empty_s;
  assign data_addr       = data_addr_r;
  assign data_wr_data    = data_wr_data_r;
  assign data_wr_mask    = data_wr_mask_r;
  assign data_wr_en      = data_wr_en_r;
  assign data_req        = data_req_r;

endmodule
